// File: rtl/serial_word_collector_if.sv
// Bus bundle for the serial word collector: bit-serial lane input side plus
// the word drain handshake and status flags.
interface serial_word_collector_if #(
  parameter int LANES = 64,
  parameter int WIDTH = 16,
  parameter int IDXW  = 6
);
  logic [LANES-1:0] bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic [WIDTH-1:0] word_out;
  logic [IDXW-1:0]  word_idx;
  logic             word_valid;
  logic             word_ready;
  logic             frame_done;
  logic             overflow;

  modport master (
    output bit_in, bit_valid, frame_start, word_ready,
    input  word_out, word_idx, word_valid, frame_done, overflow
  );

  modport slave (
    input  bit_in, bit_valid, frame_start, word_ready,
    output word_out, word_idx, word_valid, frame_done, overflow
  );
endinterface

// File: rtl/serial_word_collector.sv
// Reassembles LANES bit-serial MSB-first words into a frame and drains it
// one word per cycle over valid/ready, double-buffered against the shifters.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | drain buffer empty, word_valid low
// ST_DRAIN | presenting drain_q[idx]; advances on accept
module serial_word_collector #(
  parameter int LANES = 64,
  parameter int WIDTH = 16,
  parameter int IDXW  = 6
) (
  input  logic               clk,
  input  logic               resetn,
  serial_word_collector_if.slave bus
);
  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_DRAIN = 1'b1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  logic [LANES-1:0][WIDTH-1:0] lane_q;
  logic [LANES-1:0][WIDTH-1:0] lane_nxt;
  logic [LANES-1:0][WIDTH-1:0] drain_q;
  logic [CNTW-1:0]             bit_cnt;
  logic [CNTW-1:0]             beat_pos;
  logic [0:0]                  state;
  logic [IDXW-1:0]             idx;
  logic                        frame_done_q;
  logic                        overflow_q;
  logic                        complete;
  logic                        accept;
  logic                        last_accept;
  logic                        buf_free;
  logic                        capture;

  // frame_start restarts the beat position, discarding any partial frame
  always_comb begin
    beat_pos    = bus.frame_start ? '0 : bit_cnt;
    complete    = bus.bit_valid && (beat_pos == LAST_BIT);
    accept      = (state == ST_DRAIN) && bus.word_ready;
    last_accept = accept && (idx == LAST_IDX);
    buf_free    = (state == ST_IDLE) || last_accept;
    capture     = complete && buf_free;
    for (int i = 0; i < LANES; i++) begin
      if (bus.frame_start)
        lane_nxt[i] = WIDTH'(bus.bit_in[i]);
      else
        lane_nxt[i] = {lane_q[i][WIDTH-2:0], bus.bit_in[i]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_q  <= '0;
      bit_cnt <= '0;
    end else if (bus.bit_valid) begin
      lane_q  <= lane_nxt;
      bit_cnt <= complete ? '0 : beat_pos + CNTW'(1);
    end
  end

  // capture while draining can only happen together with the last accept,
  // so it takes priority and restarts the drain at lane 0 without a gap
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drain_q      <= '0;
      state        <= ST_IDLE;
      idx          <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= capture;
      if (complete && !buf_free)
        overflow_q <= 1'b1;
      if (capture) begin
        drain_q <= lane_nxt;
        state   <= ST_DRAIN;
        idx     <= '0;
      end else if (last_accept) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else if (accept) begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  assign bus.word_valid = (state == ST_DRAIN);
  assign bus.word_out   = (state == ST_DRAIN) ? drain_q[idx] : '0;
  assign bus.word_idx   = idx;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: frame vectors, multi-cycle corner cases and
// random traffic checked against a queue-based reference model.
module tb_serial_word_collector;
  localparam int LANES = 64;
  localparam int WIDTH = 16;
  localparam int IDXW  = 6;

  typedef struct packed {
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] w;
  } ent_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] step;
    int          garbage;
    int          stall_a;
    int          stall_b;
    bit          tog;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_count;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  serial_word_collector_if #(.LANES(LANES), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  serial_word_collector #(.LANES(LANES), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  logic [15:0]      fw [LANES];
  ent_t             got [$];
  logic [LANES-1:0] m_beats [$];
  ent_t             m_q [$];
  bit               m_done;
  bit               m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_beats.delete();
    m_q.delete();
    m_done = 0;
    m_ovf  = 0;
  endtask

  // frame = WIDTH valid beats since the last frame_start or completion
  task automatic model_step(input logic [LANES-1:0] b, input bit bv, input bit fs, input bit rdy);
    int  n;
    bit  acc, free;
    ent_t e;
    n    = m_q.size();
    acc  = (n > 0) && rdy;
    free = (n == 0) || (acc && n == 1);
    if (acc) void'(m_q.pop_front());
    m_done = 0;
    if (bv) begin
      if (fs) m_beats.delete();
      m_beats.push_back(b);
      if (m_beats.size() == WIDTH) begin
        if (free) begin
          for (int i = 0; i < LANES; i++) begin
            e.idx = IDXW'(i);
            for (int k = 0; k < WIDTH; k++) e.w[WIDTH-1-k] = m_beats[k][i];
            m_q.push_back(e);
          end
          m_done = 1;
        end else begin
          m_ovf = 1;
        end
        m_beats.delete();
      end
    end
  endtask

  task automatic tick(input logic [LANES-1:0] b, input bit bv, input bit fs, input bit rdy);
    bus.bit_in      = b;
    bus.bit_valid   = bv;
    bus.frame_start = fs;
    bus.word_ready  = rdy;
    if (bus.word_valid && rdy) got.push_back({bus.word_idx, bus.word_out});
    model_step(b, bv, fs, rdy);
    @(posedge clk);
    #1;
    cyc++;
    chk("valid", 32'(bus.word_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("word", 32'(bus.word_out), 32'(m_q[0].w));
      chk("idx", 32'(bus.word_idx), 32'(m_q[0].idx));
    end
    chk("done", 32'(bus.frame_done), 32'(m_done));
    chk("ovf", 32'(bus.overflow), 32'(m_ovf));
    if (bus.frame_done) done_cnt++;
  endtask

  function automatic logic [LANES-1:0] beat(input int k);
    logic [LANES-1:0] b;
    for (int i = 0; i < LANES; i++) b[i] = fw[i][WIDTH-1-k];
    return b;
  endfunction

  function automatic logic [LANES-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  function automatic bit rdy_of(input bit tog);
    return tog ? bit'(cyc % 2) : 1'b1;
  endfunction

  task automatic fill(input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < LANES; i++) fw[i] = base + step * 16'(i);
  endtask

  task automatic send_frame(input int sa, input int sb, input bit tog);
    for (int k = 0; k < WIDTH; k++) begin
      if (k == sa || k == sb) tick(rnd(), 1'b0, bit'($urandom_range(0, 1)), rdy_of(tog));
      tick(beat(k), 1'b1, k == 0, rdy_of(tog));
    end
  endtask

  task automatic drain(input int n, input bit tog);
    for (int j = 0; j < n; j++) tick(rnd(), 1'b0, 1'b0, rdy_of(tog));
  endtask

  function automatic int seq_err(input int off, input logic [15:0] base, input logic [15:0] step);
    int err = 0;
    for (int i = 0; i < LANES; i++) begin
      if (off + i >= got.size()) err++;
      else if (got[off+i].idx != IDXW'(i) || got[off+i].w != 16'(base + step * 16'(i))) err++;
    end
    return err;
  endfunction

  function automatic logic [31:0] got_w(input int i);
    if (i < 0 || i >= got.size()) return 32'hFFFF_FFFF;
    return 32'(got[i].w);
  endfunction

  task automatic reset_dut();
    resetn = 1'b0;
    bus.bit_in = '0;
    bus.bit_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    got.delete();
    done_cnt = 0;
    resetn = 1'b1;
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    resetn = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(bus.word_valid), 0);
    chk({tag, "_word"}, 32'(bus.word_out), 0);
    chk({tag, "_idx"}, 32'(bus.word_idx), 0);
    chk({tag, "_done"}, 32'(bus.frame_done), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 0);
    @(posedge clk);
    #1;
    model_reset();
    got.delete();
    done_cnt = 0;
    resetn = 1'b1;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{16'hA500, 16'h0001, 0, -1, -1, 1'b0, 16'hA500, 16'hA53F, 64};
    vecs[1] = '{16'hA500, 16'h0001, 0,  3,  9, 1'b1, 16'hA500, 16'hA53F, 64};
    vecs[2] = '{16'h8001, 16'h0000, 5, -1, -1, 1'b0, 16'h8001, 16'h8001, 64};
    vecs[3] = '{16'h0000, 16'h0101, 0, -1, -1, 1'b1, 16'h0000, 16'h3F3F, 64};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 2,  0, 15, 1'b0, 16'hFFFF, 16'hFFC0, 64};

    resetn = 1'b0;
    bus.bit_in = '0;
    bus.bit_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.word_valid), 0);
    chk("rst_word", 32'(bus.word_out), 0);
    chk("rst_idx", 32'(bus.word_idx), 0);
    chk("rst_done", 32'(bus.frame_done), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    model_reset();
    resetn = 1'b1;

    for (int v = 0; v < 5; v++) begin
      reset_dut();
      for (int g = 0; g < vecs[v].garbage; g++) tick(rnd(), 1'b1, g == 0, 1'b1);
      fill(vecs[v].base, vecs[v].step);
      send_frame(vecs[v].stall_a, vecs[v].stall_b, vecs[v].tog);
      drain(160, vecs[v].tog);
      chk("vec_count", 32'(got.size()), 32'(vecs[v].exp_count));
      chk("vec_first", got_w(0), 32'(vecs[v].exp_first));
      chk("vec_last", got_w(vecs[v].exp_count - 1), 32'(vecs[v].exp_last));
      chk("vec_seq", 32'(seq_err(0, vecs[v].base, vecs[v].step)), 0);
      chk("vec_frame_done", 32'(done_cnt), 1);
      chk("vec_ovf", 32'(bus.overflow), 0);
      chk("vec_idle", 32'(bus.word_valid), 0);
    end

    // second frame completes with 10 words of the first still pending
    reset_dut();
    fill(16'hA500, 16'h0001);
    send_frame(-1, -1, 1'b0);
    drain(38, 1'b0);
    fill(16'h1234, 16'h0000);
    send_frame(-1, -1, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 1);
    drain(80, 1'b0);
    chk("ovf_count", 32'(got.size()), 64);
    chk("ovf_seq", 32'(seq_err(0, 16'hA500, 16'h0001)), 0);
    chk("ovf_idle", 32'(bus.word_valid), 0);
    chk("ovf_done_cnt", 32'(done_cnt), 1);

    // last beat of frame 2 on the same edge as the accept of idx 63
    reset_dut();
    fill(16'hA500, 16'h0001);
    send_frame(-1, -1, 1'b0);
    drain(48, 1'b0);
    fill(16'h1234, 16'h0000);
    send_frame(-1, -1, 1'b0);
    chk("b2b_valid", 32'(bus.word_valid), 1);
    chk("b2b_word", 32'(bus.word_out), 32'h1234);
    chk("b2b_idx", 32'(bus.word_idx), 0);
    chk("b2b_ovf", 32'(bus.overflow), 0);
    chk("b2b_done", 32'(bus.frame_done), 1);
    drain(80, 1'b0);
    chk("b2b_count", 32'(got.size()), 128);
    chk("b2b_seq1", 32'(seq_err(0, 16'hA500, 16'h0001)), 0);
    chk("b2b_seq2", 32'(seq_err(64, 16'h1234, 16'h0000)), 0);

    // asynchronous reset mid-drain and mid-shift
    reset_dut();
    fill(16'hA500, 16'h0001);
    send_frame(-1, -1, 1'b0);
    drain(20, 1'b0);
    chk("pre_rst_idx", 32'(bus.word_idx), 20);
    async_reset_check("mid_drain");
    fill(16'h5A5A, 16'h0003);
    for (int k = 0; k < 7; k++) tick(beat(k), 1'b1, k == 0, 1'b1);
    async_reset_check("mid_shift");
    fill(16'h0F00, 16'h0001);
    send_frame(-1, -1, 1'b0);
    drain(80, 1'b0);
    chk("post_rst_count", 32'(got.size()), 64);
    chk("post_rst_seq", 32'(seq_err(0, 16'h0F00, 16'h0001)), 0);

    // random traffic against the reference model
    reset_dut();
    for (int j = 0; j < 3000; j++) begin
      bit bv, fs, rdy;
      bv  = ($urandom_range(0, 9) < 8);
      fs  = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tick(rnd(), bv, fs, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Receive end of the bit-serial weight lane interface. Accepts LANES parallel bit-serial streams, each carrying one WIDTH-bit word MSB-first, one bit per lane per beat.
- Reassembles one word per lane and hands the completed frame to a drain buffer.
- Emits the words one per cycle, lane 0 first, over a valid/ready handshake to the downstream writer.
- Double-buffered, so a new frame can be shifted in while the previous frame drains.

Parameters:
- LANES, 64, number of serial lanes (words per frame).
- WIDTH, 16, bits per word / beats per frame.
- IDXW, 6, width of word_idx; equals clog2(LANES).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- resetn  input  1  asynchronous active-low reset.
- bit_in  input  LANES  one serial bit per lane; bit_in[i] belongs to lane i.
- bit_valid  input  1  bit_in holds a valid beat this cycle.
- frame_start  input  1  qualified by bit_valid; this beat is bit 0 (MSB) of a new frame.
- word_out  output  WIDTH  current drained word.
- word_idx  output  IDXW  lane index of word_out.
- word_valid  output  1  word_out/word_idx are valid.
- word_ready  input  1  downstream accepts word_out this cycle.
- frame_done  output  1  one-cycle pulse when a frame is transferred into the drain buffer.
- overflow  output  1  sticky: a frame completed while the drain buffer was still occupied.

Behaviour:
- Reset (resetn=0, asynchronous, at any time including mid-frame or mid-drain):
  - All lane shift registers, drain buffer, bit counter and drain index cleared to 0.
  - word_valid=0, word_out=0, word_idx=0, frame_done=0, overflow=0.
  - Partial frames are discarded.
- Shift stage:
  - On each posedge with bit_valid=1, every lane register shifts left: lane[i] <= {lane[i][WIDTH-2:0], bit_in[i]}.
  - The first received bit therefore ends up as the MSB.
  - bit_cnt counts 0..WIDTH-1.
  - bit_valid=0: lane registers and bit_cnt hold.
  - frame_start=1 with bit_valid=1 forces this beat to be bit 0. bit_cnt becomes 1 and the previous partial frame is discarded (resync).
  - frame_start without bit_valid is ignored.
- Frame completion: the beat with bit_cnt==WIDTH-1 (and bit_valid=1) completes the frame, and bit_cnt wraps to 0.
  - If the drain buffer is free, buf[i] <= {lane[i][WIDTH-2:0], bit_in[i]} on the same edge. frame_done pulses for the following cycle and the drain FSM enters DRAIN with idx=0.
  - Buffer free = FSM in IDLE, or FSM in DRAIN with idx==LANES-1 and word_valid&word_ready in that same cycle (simultaneous last-accept and new frame: the new frame is accepted, with no gap and no overflow).
  - If the buffer is not free: the new frame is dropped, the buffer is untouched, overflow is set (sticky until reset), and frame_done stays 0.
- Drain FSM, states IDLE and DRAIN:
  - IDLE: word_valid=0. Moves to DRAIN on frame capture.
  - DRAIN: word_valid=1, word_out=buf[idx], word_idx=idx. Registered, so first valid appears the cycle after the completing beat (latency 1).
  - On word_valid&word_ready: idx increments. After idx==LANES-1 is accepted, the FSM returns to IDLE, unless a new frame is captured on the same edge, in which case it stays in DRAIN with idx=0.
  - word_ready=0 holds word_out/word_idx stable; valid must not drop without acceptance.
- Throughput: the drain needs LANES accepting cycles and a frame needs WIDTH beats. With LANES>WIDTH, a continuous stream overflows unless the source idles; it is the upstream controller's duty to pace frames.
- Index arithmetic is unsigned IDXW-bit. idx never exceeds LANES-1.

Test Plan:
- Reset, then one frame with lane i carrying word 16'hA500+i (MSB first, 16 beats, frame_start on beat 0), word_ready=1 → frame_done pulses once; 64 words 16'hA500..16'hA53F with word_idx 0..63 on consecutive cycles; word_valid then 0; overflow=0.
- Same frame with bit_valid deasserted on beats 3 and 9, and word_ready toggled 1/0 → identical words; word_out stable while ready=0; no word skipped or duplicated.
- 5 beats of garbage, then frame_start plus a full frame with all lanes 16'h8001 → all 64 words are 16'h8001 (resync discards partial).
- Second frame (all lanes 16'h1234) completes while 10 words of the first remain, ready=1 → second frame dropped; overflow=1; first frame drains intact; word_valid falls after idx 63.
- Pace the second frame so its last beat coincides with acceptance of idx 63 of the first → word_valid stays high; next word is 16'h1234 idx 0; overflow=0.
- Assert resetn=0 asynchronously mid-drain (idx=20) and mid-shift → outputs 0 immediately, without a clock edge; after release, a fresh frame drains from idx 0 correctly.
